// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } pc_state_t;

    localparam int LUT_IDX_W = 4;
    localparam int LUT_TGT_W = 8;

endpackage

// File: rtl/prog_counter.sv
// Instruction-fetch program counter with Start/Done run handshake and a
// saturating run-cycle counter.
//
// state | meaning
// IDLE  | out of reset, waiting for Start
// ARMED | Start held high; PC and CycleCount parked at their start values
// RUN   | fetching; PC increments, branches or holds each cycle
// DONE  | halted; PC and CycleCount frozen, Done high until Start
module prog_counter
    import cpu_pkg::*;
#(
    parameter int               PC_W       = 8,
    parameter logic [PC_W-1:0]  START_ADDR = '0,
    parameter int               CNT_W      = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Halt,
    input  logic                 Stall,
    input  logic                 BranchEn,
    input  logic                 BranchTaken,
    input  logic [LUT_IDX_W-1:0] LutIdx,
    input  logic [LUT_TGT_W-1:0] Target,
    output logic [LUT_IDX_W-1:0] LutAddr,
    output logic [PC_W-1:0]      PC,
    output logic                 InstrValid,
    output logic                 Done,
    output logic [CNT_W-1:0]     CycleCount
);

    pc_state_t        state, state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             done_nxt;

    assign LutAddr = LutIdx;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            PC         <= START_ADDR;
            Done       <= 1'b0;
            CycleCount <= '0;
        end else begin
            state      <= state_nxt;
            PC         <= pc_nxt;
            Done       <= done_nxt;
            CycleCount <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start)  state_nxt = ARMED;
            ARMED:   if (!Start) state_nxt = RUN;
            RUN: begin
                if (Start)      state_nxt = ARMED;
                else if (Halt)  state_nxt = DONE;
            end
            DONE:    if (Start)  state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    // Halt and Stall both outrank a taken branch; a stalled branch is simply
    // presented again next cycle by the decoder.
    always_comb begin
        pc_nxt = PC;
        if (Start || state == ARMED) begin
            pc_nxt = START_ADDR;
        end else if (state == RUN && !Halt && !Stall) begin
            if (BranchEn && BranchTaken)
                pc_nxt = PC_W'(Target);
            else
                pc_nxt = PC + PC_W'(1);
        end
    end

    always_comb begin
        cnt_nxt = CycleCount;
        if (state == ARMED || state_nxt == ARMED)
            cnt_nxt = '0;
        else if (state == RUN && CycleCount != {CNT_W{1'b1}})
            cnt_nxt = CycleCount + CNT_W'(1);
    end

    always_comb begin
        done_nxt   = (state_nxt == DONE);
        InstrValid = (state == RUN) && !Stall;
    end

endmodule
